pipemem_stage: RTL

- Combines the EXE/MEM pipeline register with the data-memory access controller for the 5-stage pipelined CPU.
- Captures the EXE stage results (ALU result, store data, destination register, control bits) and issues a req/ack transaction to an external data memory for loads and stores.
- Stalls the upstream pipeline while a transaction is outstanding.
- Presents MEM/WB-ready values and forwarding sources (malu, mrn, mwreg).

---
 rtl/pipemem_stage_if.sv | 28 ++
 rtl/pipemem_stage.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/pipemem_stage_if.sv
// Data-memory bus between the MEM pipeline stage and the external data memory.
// The stage drives the request side; the memory answers with read data and a one-cycle ack.
interface pipemem_stage_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata,
    output mem_ack
  );
endinterface

// File: rtl/pipemem_stage.sv
// EXE/MEM pipeline register merged with the data-memory req/ack controller.
// The upstream pipeline is held through mstall while a load or store is outstanding.
module pipemem_stage #(
  parameter int TIMEOUT = 16,
  parameter int CW      = 5
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 ewreg,
  input  logic                 em2reg,
  input  logic                 ewmem,
  input  logic [31:0]          ealu,
  input  logic [31:0]          eb,
  input  logic [4:0]           ern,
  pipemem_stage_if.master      mem,
  output logic                 mwreg,
  output logic                 mm2reg,
  output logic [31:0]          malu,
  output logic [31:0]          mmo,
  output logic [4:0]           mrn,
  output logic                 mstall,
  output logic                 merr
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam bit            TO_EN = (TIMEOUT != 0);
  localparam logic [CW-1:0] TLAST = CW'(TIMEOUT - 1);

  state_t        state_r;
  state_t        state_s;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_s;
  logic          req_r;
  logic          req_s;
  logic [31:0]   mmo_r;
  logic [31:0]   mmo_s;
  logic          merr_r;
  logic          merr_s;
  logic          capture_s;

  logic          wreg_r;
  logic          m2reg_r;
  logic          wmem_r;
  logic [31:0]   alu_r;
  logic [31:0]   b_r;
  logic [4:0]    rn_r;

  // Next-state, timeout counter, load-data and error-flag logic.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    mmo_s     = mmo_r;
    merr_s    = merr_r;
    capture_s = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        // Not stalled: a new instruction enters M this edge; DONE may chain straight into REQ.
        capture_s = 1'b1;
        cnt_s     = {CW{1'b0}};
        if (em2reg || ewmem) begin
          state_s = ST_REQ;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (mem.mem_ack) begin
          state_s = ST_DONE;
          if (m2reg_r) begin
            mmo_s = mem.mem_rdata;
          end else begin
            mmo_s = mmo_r;
          end
        end else if (TO_EN && (cnt_r == TLAST)) begin
          // Forced completion: a timed-out load returns zero rather than stale data.
          state_s = ST_DONE;
          merr_s  = 1'b1;
          if (m2reg_r) begin
            mmo_s = 32'h0000_0000;
          end else begin
            mmo_s = mmo_r;
          end
        end else begin
          state_s = ST_REQ;
          cnt_s   = cnt_r + CW'(1);
        end
      end
      default: begin
        state_s   = ST_IDLE;
        cnt_s     = {CW{1'b0}};
        capture_s = 1'b0;
      end
    endcase
    req_s = (state_s == ST_REQ);
  end

  // Controller registers: state, counter, request/stall flag, load data, sticky error.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CW{1'b0}};
      req_r   <= 1'b0;
      mmo_r   <= 32'h0000_0000;
      merr_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      req_r   <= req_s;
      mmo_r   <= mmo_s;
      merr_r  <= merr_s;
    end
  end

  // EXE/MEM pipeline register; frozen while a memory access is outstanding.
  always_ff @(posedge clock) begin
    if (reset) begin
      wreg_r  <= 1'b0;
      m2reg_r <= 1'b0;
      wmem_r  <= 1'b0;
      alu_r   <= 32'h0000_0000;
      b_r     <= 32'h0000_0000;
      rn_r    <= 5'd0;
    end else if (capture_s) begin
      wreg_r  <= ewreg;
      m2reg_r <= em2reg;
      wmem_r  <= ewmem;
      alu_r   <= ealu;
      b_r     <= eb;
      rn_r    <= ern;
    end else begin
      wreg_r  <= wreg_r;
      m2reg_r <= m2reg_r;
      wmem_r  <= wmem_r;
      alu_r   <= alu_r;
      b_r     <= b_r;
      rn_r    <= rn_r;
    end
  end

  assign mem.mem_req   = req_r;
  assign mem.mem_we    = wmem_r;
  assign mem.mem_addr  = alu_r;
  assign mem.mem_wdata = b_r;

  // WB must not commit a load until its data has landed, so the write enable is masked by the stall.
  assign mwreg  = wreg_r & ~req_r;
  assign mm2reg = m2reg_r;
  assign malu   = alu_r;
  assign mmo    = mmo_r;
  assign mrn    = rn_r;
  assign mstall = req_r;
  assign merr   = merr_r;

endmodule
